// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   PC_W       program counter / instruction memory address width
//   INS_W      instruction width
//   NOP_INSTR  bubble value shown on if_instr when no instruction is available
//   fq_entry_t one fetch queue entry: the PC and the instruction fetched from it
package fetch_pkg;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  localparam logic [INS_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus.
//   req/addr   fetch request and address (fetch unit -> memory)
//   gnt        request accepted this cycle (memory -> fetch unit)
//   rvalid     in-order response valid (memory -> fetch unit)
//   rdata      returned instruction (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if #(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int INS_W = fetch_pkg::INS_W
);

  logic             req;
  logic [PC_W-1:0]  addr;
  logic             gnt;
  logic             rvalid;
  logic [INS_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: small synchronous FIFO with flush.
//   clk, reset  clock, asynchronous active-low reset
//   push, din   write din at the tail
//   pop         drop the head entry
//   flush       empty the queue; overrides push and pop
//   full, empty, count  occupancy status
//   head        head entry (meaningless while empty)
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // which keeps the array a plain register file without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(push && full && !flush));
  assert property (@(posedge clk) disable iff (!reset) !(pop && empty && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipeline front end feeding the IF/ID register.
//   clk, reset        clock, asynchronous active-low reset
//   stall             hold the IF/ID output (head entry)
//   redirect_valid/pc flush and restart fetch at redirect_pc
//   imem              instruction memory bus (master side)
//   if_valid/pc/instr head of the fetch queue; zero bubble when empty
// Requests are issued in order; responses return in order. Space for every
// outstanding response is reserved in the queue before the request is made.
// After a redirect, responses still in flight for the old path are counted
// down in drop_cnt and discarded.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_W-1:0]      redirect_pc,
  instr_fetch_unit_if.master   imem,
  output logic                 if_valid,
  output logic [PC_W-1:0]      if_pc,
  output logic [INS_W-1:0]     if_instr
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fq_count;
  logic [CW:0]     in_use;
  logic            fq_full;
  logic            fq_empty;
  logic            grant;
  logic            accept;
  logic            pop;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  always_comb begin
    in_use = {1'b0, fq_count} + {1'b0, outstanding};
    // Reset gates the request combinationally so it drops the instant reset
    // asserts, abandoning the burst in progress.
    imem.req   = reset && (in_use < (CW+1)'(FQ_DEPTH)) && !redirect_valid;
    imem.addr  = fetch_pc;
    grant      = imem.req && imem.gnt;
    // A response in the redirect cycle is wrong-path by definition.
    accept     = imem.rvalid && (drop_cnt == '0) && !redirect_valid;
    pop        = !fq_empty && !stall && !redirect_valid;
    push_entry = '{pc: resp_pc, instr: imem.rdata};
  end

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count),
    .head  (head)
  );

  assign if_valid = !fq_empty;
  assign if_pc    = fq_empty ? '0 : head.pc;
  assign if_instr = fq_empty ? NOP_INSTR : head.instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // No grant is possible this cycle, so only the response can retire one.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - CW'(imem.rvalid);
      drop_cnt    <= outstanding - CW'(imem.rvalid);
    end else begin
      if (grant)  fetch_pc <= fetch_pc + PC_W'(4);
      if (accept) resp_pc  <= resp_pc + PC_W'(4);
      if (imem.rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(imem.rvalid);
    end
  end

  // A full queue leaves no room for a response, so nothing may be in flight.
  assert property (@(posedge clk) disable iff (!reset) !(fq_full && (outstanding != '0)));
  assert property (@(posedge clk) disable iff (!reset) !(imem.rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int FQ_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stall = 1'b0;
  logic             redirect_valid = 1'b0;
  logic [PC_W-1:0]  redirect_pc = '0;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  instr_fetch_unit_if imem ();

  instr_fetch_unit #(
    .FQ_DEPTH (FQ_DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  // Memory model: in-order list of granted requests with their earliest
  // response cycle.
  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } mreq_t;

  mreq_t           pend[$];
  // Reference model: the fetch queue as a plain queue of {pc, instr}.
  fq_entry_t       mq[$];
  int              m_out;
  int              m_drop;
  logic [PC_W-1:0] m_fpc;
  logic [PC_W-1:0] m_rpc;
  int              cyc;
  int              checks;
  int              errors;

  function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {7'h5a, a, 7'h33, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    m_out  = 0;
    m_drop = 0;
    m_fpc  = '0;
    m_rpc  = '0;
  endtask

  // One clock cycle: drive inputs at posedge+1, compare at negedge, advance
  // the model, return at the next posedge+1.
  task automatic cycle(input bit st, input bit rd, input logic [PC_W-1:0] rpc,
                       input bit g, input bit rv_en, input int lat);
    bit               rv;
    bit               e_req;
    bit               gr;
    logic [INS_W-1:0] rdat;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem.gnt       = g;
    rv   = rv_en && (pend.size() > 0) && (pend[0].due <= cyc);
    rdat = rv ? mem_word(pend[0].addr) : INS_W'($urandom);
    imem.rvalid = rv;
    imem.rdata  = rdat;
    @(negedge clk);
    e_req = ((mq.size() + m_out) < FQ_DEPTH) && !rd;
    check("imem_req",  32'(imem.req),  32'(e_req));
    check("imem_addr", 32'(imem.addr), 32'(m_fpc));
    check("if_valid",  32'(if_valid),  32'(mq.size() > 0));
    check("if_pc",     32'(if_pc),     (mq.size() > 0) ? 32'(mq[0].pc) : 32'd0);
    check("if_instr",  if_instr,       (mq.size() > 0) ? mq[0].instr : 32'd0);
    gr = e_req && g;
    if (rv) pend.delete(0);
    if (gr) pend.push_back('{addr: m_fpc, due: cyc + lat});
    if (rd) begin
      mq.delete();
      m_out  = m_out - int'(rv);
      m_drop = m_out;
      m_fpc  = rpc;
      m_rpc  = rpc;
    end else begin
      if ((mq.size() > 0) && !st) mq.delete(0);
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          mq.push_back('{pc: m_rpc, instr: rdat});
          m_rpc = m_rpc + PC_W'(4);
        end
      end
      m_out = m_out + int'(gr) - int'(rv);
      if (gr) m_fpc = m_fpc + PC_W'(4);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem.gnt       = 1'b0;
    imem.rvalid    = 1'b0;
    reset          = 1'b0;
    #2;
    check("rst_if_valid",  32'(if_valid),  32'd0);
    check("rst_imem_req",  32'(imem.req),  32'd0);
    check("rst_if_pc",     32'(if_pc),     32'd0);
    check("rst_if_instr",  if_instr,       32'd0);
    check("rst_imem_addr", 32'(imem.addr), 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_valid(input string name, input int lat);
    for (int i = 0; i < 20 && !if_valid; i++) cycle(0, 0, '0, 1, 1, lat);
    check(name, 32'(if_valid), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    model_clear();
    #1;

    // Zero-wait memory: PCs 0,4,8,12 on consecutive cycles from cycle 2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) check("s1_if_pc", 32'(if_pc), 32'(4 * (k - 2)));
      cycle(0, 0, '0, 1, 1, 1);
    end

    // Stall for 6 cycles: queue fills, request drops, head holds at 0.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1, 0, '0, 1, 1, 1);
    check("s2_req_low", 32'(imem.req), 32'd0);
    check("s2_hold_pc", 32'(if_pc),    32'd0);
    for (int k = 0; k < 5; k++) begin
      check("s2_pop_pc", 32'(if_pc), 32'(4 * k));
      cycle(0, 0, '0, 1, 1, 1);
    end

    // Latency 3, two outstanding, redirect to 0x40: stale responses dropped.
    do_reset();
    cycle(0, 0, '0, 1, 1, 3);
    cycle(0, 0, '0, 1, 1, 3);
    cycle(0, 1, 9'h040, 0, 1, 3);
    wait_valid("s3_seen", 3);
    check("s3_first_pc", 32'(if_pc), 32'h40);
    cycle(0, 0, '0, 1, 1, 3);
    check("s3_second_pc", 32'(if_pc), 32'h44);

    // Redirect, response and stall together: response discarded.
    do_reset();
    cycle(0, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    cycle(1, 1, 9'h100, 1, 1, 1);
    check("s4_empty",  32'(if_valid), 32'd0);
    check("s4_bubble", if_instr,      32'd0);
    wait_valid("s4_seen", 1);
    check("s4_new_pc", 32'(if_pc), 32'h100);

    // Wrap-around from 0x1F8.
    do_reset();
    cycle(0, 1, 9'h1F8, 0, 1, 1);
    wait_valid("s5_seen", 1);
    check("s5_pc0", 32'(if_pc), 32'h1F8);
    cycle(0, 0, '0, 1, 1, 1);
    check("s5_pc1", 32'(if_pc), 32'h1FC);
    cycle(0, 0, '0, 1, 1, 1);
    check("s5_pc2", 32'(if_pc), 32'h000);
    cycle(0, 0, '0, 1, 1, 1);
    check("s5_pc3", 32'(if_pc), 32'h004);

    // Reset mid-burst with 3 entries queued, then restart at RESET_PC.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 0, '0, 1, 1, 1);
    check("s6_pre_valid", 32'(if_valid), 32'd1);
    do_reset();
    check("s6_restart_addr", 32'(imem.addr), 32'd0);
    wait_valid("s6_seen", 1);
    check("s6_restart_pc", 32'(if_pc), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0,
            PC_W'($urandom_range(0, 127) * 4),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 7,
            int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Pipeline front end that sits directly upstream of the IF/ID register.
- Generates the fetch PC and issues in-order requests to an instruction memory with variable latency, using a req/gnt/rvalid handshake.
- Buffers returned instructions in a small fetch queue and presents the head entry (PC and instruction) to IF/ID.
- Honours stalls from the hazard-detection unit and redirects (taken branch, JAL, JALR) from the branch unit, discarding any wrong-path responses still in flight.

Parameters:
- PC_W, 9, program counter / instruction memory address width.
- INS_W, 32, instruction width.
- FQ_DEPTH, 4, fetch queue entries; power of two, minimum 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-detection stall; holds the IF/ID output.
- redirect_valid  input  1  branch unit: flush and restart fetch.
- redirect_pc  input  PC_W  new fetch target.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order.
- imem_rdata  input  INS_W  fetched instruction.
- if_valid  output  1  head entry valid.
- if_pc  output  PC_W  PC of the head entry.
- if_instr  output  INS_W  instruction of the head entry.

Behaviour:
- Reset (reset = 0, asynchronous):
  - fetch_pc = RESET_PC and resp_pc = RESET_PC.
  - Queue is empty; outstanding = 0; drop_cnt = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, if_valid = 0, if_pc = 0, if_instr = 0.
  - Asserting reset mid-operation abandons all in-flight requests. Responses arriving after reset deasserts are not counted and must not occur; the memory is reset together with this block.
- Issue:
  - imem_req = (fq_count + outstanding < FQ_DEPTH) && !redirect_valid.
  - imem_addr = fetch_pc.
  - A request is granted when imem_req && imem_gnt. On grant: fetch_pc += 4, modulo 2^PC_W (wrap-around is legal), and outstanding++.
- Response:
  - On imem_rvalid: outstanding--.
  - If drop_cnt > 0: drop_cnt-- and the data is discarded.
  - Otherwise: push {resp_pc, imem_rdata} into the queue and resp_pc += 4, modulo 2^PC_W.
  - Grant and response in the same cycle leave outstanding unchanged.
- Queue capacity: fq_count + outstanding never exceeds FQ_DEPTH, so a push never overflows. A push while full is an assertion failure.
- Output:
  - if_valid = queue not empty; if_pc and if_instr come from the head entry.
  - When empty, if_pc = 0 and if_instr = 0 (bubble, matching the IF/ID flush value).
  - Pop = if_valid && !stall && !redirect_valid.
  - No bypass: a response accepted in cycle t is visible on if_* in cycle t+1 at the earliest.
  - Push and pop in the same cycle: the count is unchanged and both take effect.
- Redirect (redirect_valid = 1), which wins over stall, grant and response:
  - Queue is cleared.
  - fetch_pc = redirect_pc and resp_pc = redirect_pc.
  - drop_cnt = outstanding after this cycle's rvalid decrement.
  - No grant can occur in this cycle because imem_req = 0.
  - A response arriving in the redirect cycle is discarded.
  - if_* outputs show a bubble from the next cycle until the first new-path response is accepted.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Stall: the queue head holds; issue continues while capacity allows.
- Minimum latency: grant in cycle t, rvalid at t+1 or later, if_valid at t+2.

Decomposition:
- Shared package fetch_pkg:
  - typedef fq_entry_t {logic [PC_W-1:0] pc; logic [INS_W-1:0] instr;}
  - localparam NOP_INSTR = 0.
- Sub-module fetch_fifo: parameterised by width and FQ_DEPTH, with push, pop, flush, full, empty, count and head.
- Top level: PC, outstanding and drop counters, plus the issue/response control.

Test Plan:
- Reset, then zero-wait memory (gnt = 1, rvalid one cycle later), no stall → if_pc sequence 0, 4, 8, 12 on consecutive cycles from cycle 2; imem_req stays 1.
- stall held for 6 cycles with FQ_DEPTH = 4 → queue fills to 4 entries, imem_req drops to 0, if_pc holds at 0. After release, pops resume at 4, 8, 12 with no loss or duplication.
- Memory latency 3 cycles with 2 requests outstanding, then redirect to 0x40 → both stale responses are dropped, and the next valid output is if_pc = 0x40 followed by 0x44.
- redirect_valid and imem_rvalid in the same cycle, together with stall = 1 → response discarded, queue empty next cycle, if_instr = 0.
- fetch_pc starting at 0x1F8 (PC_W = 9) → outputs 0x1F8, 0x1FC, 0x000, 0x004 (wrap-around).
- reset asserted mid-burst with 3 entries queued → if_valid = 0 and imem_req = 0 immediately; after release, fetch restarts at RESET_PC.
